// File: rtl/key_loader.sv
// Key-loading mailbox: software streams a key into a shadow buffer slot by slot,
// then commits it atomically. Optional checksum byte: define KEY_LOADER_CHECKSUM_EN.
module key_loader #(
    parameter int NUM_KEYS  = 4,
    parameter int KEY_BYTES = 10
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic [7:0]                      to_hw_sig,
    input  logic [7:0]                      to_hw_port,
    output logic [7:0]                      to_sw_sig,
    output logic [NUM_KEYS*KEY_BYTES*8-1:0] keys,
    output logic [NUM_KEYS-1:0]             key_valid,
    output logic [NUM_KEYS-1:0]             key_update,
    output logic                            busy
);

    localparam int KEY_W = KEY_BYTES * 8;
`ifdef KEY_LOADER_CHECKSUM_EN
    localparam int LIMIT = KEY_BYTES + 1;
`else
    localparam int LIMIT = KEY_BYTES;
`endif
    localparam int CNT_W  = $clog2(LIMIT + 1);
    localparam int SLOT_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(LIMIT);
    localparam logic [7:0]       NUM_KEYS_B = 8'(NUM_KEYS);

    localparam logic [7:0] CMD_IDLE   = 8'h00;
    localparam logic [7:0] CMD_OPEN   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_COMMIT = 8'h03;
    localparam logic [7:0] CMD_ABORT  = 8'h04;
    localparam logic [7:0] ST_ERR     = 8'hEE;
    localparam logic [7:0] ST_CSUM    = 8'hEC;

    typedef enum logic [1:0] {S_IDLE, S_OPEN, S_ERR} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        prev_cmd_reg;
    logic [7:0]        echo_reg, echo_next;
    logic [SLOT_W-1:0] slot_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [7:0]        shadow_reg [LIMIT];
    logic [KEY_W-1:0]  key_reg [NUM_KEYS];
    logic [NUM_KEYS-1:0] valid_reg;
    logic [NUM_KEYS-1:0] update_reg;

    logic             fire;
    logic             do_open, do_write, do_commit, do_clear;
    logic             count_full;
    logic             csum_ok;
    logic [KEY_W-1:0] shadow_key;

    assign fire       = (to_hw_sig != prev_cmd_reg);
    assign count_full = (count_reg == CNT_LIMIT);

    always_comb begin
        shadow_key = '0;
        for (int i = 0; i < KEY_BYTES; i++) begin
            shadow_key[i*8 +: 8] = shadow_reg[i];
        end
    end

`ifdef KEY_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int i = 0; i < KEY_BYTES; i++) begin
            csum = csum ^ shadow_reg[i];
        end
    end
    assign csum_ok = (csum == shadow_reg[KEY_BYTES]);
`else
    assign csum_ok = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= S_IDLE;
            prev_cmd_reg <= CMD_IDLE;
            echo_reg     <= 8'h00;
        end else begin
            state_reg    <= state_next;
            prev_cmd_reg <= to_hw_sig;
            echo_reg     <= echo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        echo_next  = echo_reg;
        do_open    = 1'b0;
        do_write   = 1'b0;
        do_commit  = 1'b0;
        do_clear   = 1'b0;
        if (fire) begin
            if (state_reg == S_ERR) begin
                // The error code is held until software explicitly aborts.
                if (to_hw_sig == CMD_ABORT) begin
                    state_next = S_IDLE;
                    echo_next  = CMD_ABORT;
                    do_clear   = 1'b1;
                end
            end else begin
                case (to_hw_sig)
                    CMD_IDLE: echo_next = CMD_IDLE;
                    CMD_OPEN: begin
                        if (to_hw_port < NUM_KEYS_B) begin
                            do_open    = 1'b1;
                            state_next = S_OPEN;
                            echo_next  = CMD_OPEN;
                        end else begin
                            state_next = S_ERR;
                            echo_next  = ST_ERR;
                        end
                    end
                    CMD_WRITE: begin
                        if (state_reg == S_OPEN && !count_full) begin
                            do_write  = 1'b1;
                            echo_next = CMD_WRITE;
                        end else begin
                            state_next = S_ERR;
                            echo_next  = ST_ERR;
                        end
                    end
                    CMD_COMMIT: begin
                        if (state_reg == S_OPEN && count_full && csum_ok) begin
                            do_commit  = 1'b1;
                            state_next = S_IDLE;
                            echo_next  = CMD_COMMIT;
                        end else if (state_reg == S_OPEN && count_full) begin
                            state_next = S_ERR;
                            echo_next  = ST_CSUM;
                        end else begin
                            state_next = S_ERR;
                            echo_next  = ST_ERR;
                        end
                    end
                    CMD_ABORT: begin
                        state_next = S_IDLE;
                        echo_next  = CMD_ABORT;
                        do_clear   = 1'b1;
                    end
                    default: begin
                        state_next = S_ERR;
                        echo_next  = ST_ERR;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_reg   <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            update_reg <= '0;
            for (int i = 0; i < LIMIT; i++) shadow_reg[i] <= 8'h00;
            for (int s = 0; s < NUM_KEYS; s++) key_reg[s] <= '0;
        end else begin
            if (do_open) slot_reg <= to_hw_port[SLOT_W-1:0];
            if (do_open || do_clear) begin
                count_reg <= '0;
                for (int i = 0; i < LIMIT; i++) shadow_reg[i] <= 8'h00;
            end else if (do_write) begin
                count_reg <= count_reg + 1'b1;
                for (int i = 0; i < LIMIT; i++) begin
                    if (count_reg == CNT_W'(i)) shadow_reg[i] <= to_hw_port;
                end
            end
            // Whole slot is replaced in one edge so the cipher never sees a mix.
            for (int s = 0; s < NUM_KEYS; s++) begin
                update_reg[s] <= do_commit && (slot_reg == SLOT_W'(s));
                if (do_commit && (slot_reg == SLOT_W'(s))) begin
                    key_reg[s]   <= shadow_key;
                    valid_reg[s] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_keys
            assign keys[gi*KEY_W +: KEY_W] = key_reg[gi];
        end
    endgenerate

    assign to_sw_sig  = echo_reg;
    assign key_valid  = valid_reg;
    assign key_update = update_reg;
    assign busy       = (state_reg == S_OPEN);

endmodule

// File: doc/key_loader.md
# key_loader

Parametrised key-loading mailbox between the NIOS II PIO ports and the encryption datapath. Software opens a key slot, streams bytes into a shadow buffer over the `to_hw_sig`/`to_sw_sig` command/echo handshake, then commits. Commit copies the whole key into the active register atomically, so the cipher never sees a half-written key. It generalises the single-key receiver to NUM_KEYS slots of KEY_BYTES bytes each and adds edge-qualified commands, bounds checking and error reporting.

## Interface
- `NUM_KEYS`, default 4: number of independent key slots (1..16).
- `KEY_BYTES`, default 10: bytes per key (1..32).
- `Clk` in 1: system clock; the NIOS PIO is in the same domain.
- `Reset_n` in 1: asynchronous, active-low reset.
- `to_hw_sig` in 8: command code from software.
- `to_hw_port` in 8: command operand (slot index or data byte).
- `to_sw_sig` out 8: registered echo/status to software.
- `keys` out NUM_KEYS\*KEY_BYTES\*8: active keys, flattened. Slot s, byte i occupies bits [(s\*KEY_BYTES+i)\*8 +: 8].
- `key_valid` out NUM_KEYS: slot s has been committed since reset.
- `key_update` out NUM_KEYS: one-cycle pulse on the bit of the slot just committed.
- `busy` out 1: a slot is open (state OPEN).

## Operation
- Command codes: 0x00 IDLE, 0x01 OPEN, 0x02 WRITE, 0x03 COMMIT, 0x04 ABORT. Status codes: 0xEE error, 0xEC checksum error (see Configuration).
- `prev_cmd` register holds the previous cycle's `to_hw_sig` and resets to 0x00.
- A command *fires* only in the cycle where `to_hw_sig != prev_cmd`. Holding a code executes it once. Software returns to 0x00 between commands.
- FSM states: IDLE, OPEN, ERR.
- IDLE:
  - OPEN with `to_hw_port < NUM_KEYS`: latch slot, clear byte counter and shadow, go to OPEN, echo 0x01.
  - OPEN with out-of-range index: go to ERR.
  - WRITE or COMMIT: go to ERR.
  - ABORT: echo 0x04, stay in IDLE.
  - IDLE command: echo 0x00.
- OPEN:
  - WRITE with counter < LIMIT: `shadow[counter] <= to_hw_port`, counter++, echo 0x02. LIMIT = KEY_BYTES.
  - WRITE with counter == LIMIT: go to ERR; the shadow is unchanged.
  - COMMIT with counter == LIMIT: `keys[slot] <= shadow`, set `key_valid[slot]`, pulse `key_update[slot]`, echo 0x03, go to IDLE.
  - COMMIT with counter != LIMIT: go to ERR.
  - ABORT: discard shadow, echo 0x04, go to IDLE.
  - OPEN: re-open the given slot with the same rules as in IDLE; a partial shadow is discarded.
  - IDLE command: echo 0x00, stay in OPEN.
- ERR:
  - Echo 0xEE (or 0xEC) continuously, whatever the command.
  - Only a firing ABORT leaves ERR: echo 0x04, go to IDLE.
  - Active keys are never modified by any error path.
- Undefined codes (0x05..0xFF) firing in any state go to ERR.
- Counter width is clog2(LIMIT+1). It never wraps; overflow is an error, not a wrap-around.

## Timing
- Reset values: `to_sw_sig`=0x00, `keys`=0, `key_valid`=0, `key_update`=0, `busy`=0. FSM=IDLE, counter=0, shadow=0.
- Reset asserted mid-load discards the shadow and all active keys.
- Command fires in cycle N: `to_sw_sig`, shadow, `busy` and FSM update at the edge ending cycle N, visible in N+1.
- Commit: `keys` and `key_valid` change at the same edge. `key_update` is high for exactly cycle N+1.
- All `keys` bits of a slot change in a single edge. Other slots are untouched.
- Software handshake: write the command, poll until `to_sw_sig` equals the command code (or the error code), then write 0x00 and poll for 0x00.

## Configuration
- `KEY_LOADER_CHECKSUM_EN` defined:
  - LIMIT = KEY_BYTES+1. The final written byte is a checksum; it is stored in shadow but never copied to `keys`.
  - COMMIT additionally requires the XOR of the KEY_BYTES key bytes to equal the checksum byte.
  - On mismatch: go to ERR with echo 0xEC; keys unchanged.
- `KEY_LOADER_CHECKSUM_EN` undefined:
  - LIMIT = KEY_BYTES. No checksum byte or logic.
  - 0xEC is never produced.

## Test plan
- Reset, then OPEN slot 2, WRITE 0x01..0x0A (each separated by 0x00), COMMIT -> `keys` slot 2 = 0x0A090807060504030201, `key_valid`=4'b0100, one `key_update`[2] pulse, echo 0x03.
- Hold WRITE 0x55 for 20 cycles after OPEN -> counter=1, exactly one byte stored, echo 0x02.
- Write 11 bytes (checksum off) -> echo 0xEE after the 11th byte. COMMIT is ignored; ABORT gives echo 0x04, IDLE, keys unchanged.
- OPEN 0x04 with NUM_KEYS=4 -> echo 0xEE. COMMIT after 9 bytes -> echo 0xEE, `key_valid` unchanged.
- Commit slot 0, then reload slot 0 with different bytes and assert `Reset_n` low after byte 5 -> all outputs 0 immediately (asynchronous reset); after release, echo 0x00.
- Checksum on: 10 bytes plus 0x0B (XOR of 0x01..0x0A) -> commit succeeds. Checksum 0x00 -> echo 0xEC, keys unchanged.
